// File: rtl/cook_timer_pkg.sv
// rtl/cook_timer_pkg.sv - shared state encoding, BCD limits and digit check for cook_timer
package cook_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic bcd_digit_ok(input logic [3:0] digit, input logic [3:0] max_digit);
    return digit <= max_digit;
  endfunction

endpackage

// File: rtl/cook_timer_bcd_digit_down.sv
// rtl/cook_timer_bcd_digit_down.sv - one BCD down-counting digit with borrow out
module bcd_digit_down #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  assign borrow_out = dec_en & (digit_q == 4'd0);
  assign digit      = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec_en) begin
      digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - BCD mm:ss countdown timer driven by the divider's tick square wave
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter bit         TICK_BOTH_EDGES = 1'b0,
  parameter logic [3:0] MAX_MIN_TENS    = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       door_open,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       load_err,
  output logic [1:0] state
);

  state_e state_q, state_d;
  logic   tick_prev_q;
  logic   running_q, running_d;
  logic   done_q, done_d;
  logic   load_err_q, load_err_d;

  logic [3:0] sec_u, sec_t, min_u, min_t;
  logic       sec_u_borrow, sec_t_borrow, min_u_borrow, min_t_borrow;

  logic        tick_pulse;
  logic        load_ok, load_valid;
  logic        time_nz, time_is_one;
  logic        dec_en;
  logic        time_ld;
  logic [15:0] time_ld_val;

  assign tick_pulse = TICK_BOTH_EDGES ? (tick_in ^ tick_prev_q) : (tick_in & ~tick_prev_q);

  assign load_ok    = load & ((state_q == IDLE) | (state_q == DONE));
  assign load_valid = bcd_digit_ok(min_in[7:4], BCD_NINE) &
                      bcd_digit_ok(min_in[7:4], MAX_MIN_TENS) &
                      bcd_digit_ok(min_in[3:0], BCD_NINE) &
                      bcd_digit_ok(sec_in[7:4], SEC_TENS_MAX) &
                      bcd_digit_ok(sec_in[3:0], BCD_NINE);

  assign time_nz     = |{min_t, min_u, sec_t, sec_u};
  assign time_is_one = ({min_t, min_u, sec_t, sec_u} == 16'h0001);

  // Door and pause outrank the tick, and a zero time never decrements.
  assign dec_en = (state_q == RUN) & tick_pulse & ~clear & ~door_open & ~pause & time_nz;

  assign time_ld     = clear | (load_ok & load_valid);
  assign time_ld_val = clear ? 16'h0000 : {min_in, sec_in};

  bcd_digit_down #(.MAX(BCD_NINE)) u_sec_units (
    .clk(clk), .rst(rst), .load(time_ld), .load_val(time_ld_val[3:0]),
    .dec_en(dec_en), .digit(sec_u), .borrow_out(sec_u_borrow)
  );

  bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .load(time_ld), .load_val(time_ld_val[7:4]),
    .dec_en(sec_u_borrow), .digit(sec_t), .borrow_out(sec_t_borrow)
  );

  bcd_digit_down #(.MAX(BCD_NINE)) u_min_units (
    .clk(clk), .rst(rst), .load(time_ld), .load_val(time_ld_val[11:8]),
    .dec_en(sec_t_borrow), .digit(min_u), .borrow_out(min_u_borrow)
  );

  bcd_digit_down #(.MAX(BCD_NINE)) u_min_tens (
    .clk(clk), .rst(rst), .load(time_ld), .load_val(time_ld_val[15:12]),
    .dec_en(min_u_borrow), .digit(min_t), .borrow_out(min_t_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_prev_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_prev_q <= tick_in;
      running_q   <= running_d;
      done_q      <= done_d;
      load_err_q  <= load_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (load_ok) begin
      if (load_valid) state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start & ~door_open & time_nz) state_d = RUN;
        end
        RUN: begin
          if (door_open | pause) begin
            state_d = PAUSE;
          end else if (dec_en & (time_is_one | min_t_borrow)) begin
            state_d = DONE;
          end
        end
        PAUSE: begin
          if (start & ~door_open) state_d = RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    running_d  = (state_d == RUN);
    done_d     = (state_d == DONE);
    load_err_d = ~clear & load_ok & ~load_valid;
  end

  assign min_bcd  = {min_t, min_u};
  assign sec_bcd  = {sec_t, sec_u};
  assign running  = running_q;
  assign done     = done_q;
  assign load_err = load_err_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cook_timer.sv
// tb/tb_cook_timer.sv - directed self-checking bench for cook_timer
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       rst, tick_in, load, start, pause, clear, door_open;
  logic [7:0] min_in, sec_in;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, done, load_err;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  always #5 clk = ~clk;

  cook_timer #(.TICK_BOTH_EDGES(1'b0), .MAX_MIN_TENS(4'd9)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .min_in(min_in), .sec_in(sec_in),
    .load(load), .start(start), .pause(pause), .clear(clear), .door_open(door_open),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .done(done),
    .load_err(load_err), .state(state)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] t, input logic [1:0] st,
                         input logic run, input logic dn, input logic le);
    chk({tag, " time"}, {min_bcd, sec_bcd}, t);
    chk({tag, " state"}, {14'd0, state}, {14'd0, st});
    chk({tag, " flags"}, {13'd0, running, done, load_err}, {13'd0, run, dn, le});
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    min_in = m; sec_in = s; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    clear = 1'b0; door_open = 1'b0; min_in = 8'h00; sec_in = 8'h00;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 16'h0000, S_IDLE, 1'b0, 1'b0, 1'b0);

    do_load(8'h01, 8'h02);
    chk_all("load 01:02", 16'h0102, S_IDLE, 1'b0, 1'b0, 1'b0);
    do_start();
    chk_all("start", 16'h0102, S_RUN, 1'b1, 1'b0, 1'b0);
    do_tick();
    chk("tick1", {min_bcd, sec_bcd}, 16'h0101);
    do_tick();
    chk("tick2", {min_bcd, sec_bcd}, 16'h0100);
    do_tick();
    chk_all("tick3 borrow", 16'h0059, S_RUN, 1'b1, 1'b0, 1'b0);

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_all("reset mid-run", 16'h0000, S_IDLE, 1'b0, 1'b0, 1'b0);

    do_load(8'h00, 8'h02);
    do_start();
    do_tick();
    chk_all("00:01", 16'h0001, S_RUN, 1'b1, 1'b0, 1'b0);
    do_tick();
    chk_all("reach zero", 16'h0000, S_DONE, 1'b0, 1'b1, 1'b0);
    do_tick();
    chk_all("tick in done", 16'h0000, S_DONE, 1'b0, 1'b1, 1'b0);
    do_start();
    chk("start in done", {14'd0, state}, {14'd0, S_DONE});

    do_load(8'h00, 8'h60);
    chk_all("bad sec load", 16'h0000, S_DONE, 1'b0, 1'b1, 1'b1);
    step();
    chk("load_err one cycle", {15'd0, load_err}, 16'd0);
    do_load(8'hA0, 8'h00);
    chk_all("bad min load", 16'h0000, S_DONE, 1'b0, 1'b1, 1'b1);
    do_load(8'h99, 8'h59);
    chk_all("max load", 16'h9959, S_IDLE, 1'b0, 1'b0, 1'b0);

    do_load(8'h10, 8'h00);
    do_start();
    do_tick();
    chk("10:00 borrow", {min_bcd, sec_bcd}, 16'h0959);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all("clear in run", 16'h0000, S_IDLE, 1'b0, 1'b0, 1'b0);

    do_load(8'h00, 8'h05);
    do_start();
    do_load(8'h00, 8'h30);
    chk_all("load in run", 16'h0005, S_RUN, 1'b1, 1'b0, 1'b0);

    door_open = 1'b1;
    step();
    chk_all("door open", 16'h0005, S_PAUSE, 1'b0, 1'b0, 1'b0);
    do_tick();
    chk("tick in pause", {min_bcd, sec_bcd}, 16'h0005);
    do_start();
    chk("start door open", {14'd0, state}, {14'd0, S_PAUSE});
    door_open = 1'b0;
    do_start();
    chk_all("resume", 16'h0005, S_RUN, 1'b1, 1'b0, 1'b0);
    do_tick();
    chk("resume tick", {min_bcd, sec_bcd}, 16'h0004);

    tick_in = 1'b1; pause = 1'b1;
    step();
    tick_in = 1'b0; pause = 1'b0;
    step();
    chk_all("tick+pause", 16'h0004, S_PAUSE, 1'b0, 1'b0, 1'b0);
    do_start();
    tick_in = 1'b1; clear = 1'b1;
    step();
    tick_in = 1'b0; clear = 1'b0;
    chk_all("tick+clear", 16'h0000, S_IDLE, 1'b0, 1'b0, 1'b0);
    step();
    do_start();
    chk_all("start at zero", 16'h0000, S_IDLE, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
